// File: rtl/oam_dma_pkg.sv
// Shared state encoding and constants for the 2A03 sprite (OAM) DMA.
// Defining OAM_DMA_ALIGN_EN adds the ALIGN state used for get/put alignment.
package oam_dma_pkg;

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_t;
`endif

    localparam logic [15:0] TRIGGER_ADDR_DEFAULT = 16'h4014;
    localparam logic [15:0] DEST_ADDR_DEFAULT    = 16'h2004;

    localparam int BYTES_PER_XFER  = 256;
    localparam int CYCLES_PER_BYTE = 2;
    // One halt cycle plus a read/write pair per byte.
    localparam int BASE_CYCLES     = 1 + BYTES_PER_XFER * CYCLES_PER_BYTE;

    function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [7:0] index);
        return {page, index};
    endfunction

endpackage

// File: rtl/oam_dma_2a03.sv
// Sprite DMA bus initiator: snoops CPU writes to the trigger address, halts the CPU and
// copies one 256-byte page to the OAM data port. Optional macro: OAM_DMA_ALIGN_EN.
module oam_dma_2a03
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = TRIGGER_ADDR_DEFAULT,
    parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data,
    input  logic [7:0]  data_in,
    output logic        dma_active,
    output logic        cpu_halt,
    output logic [15:0] addr,
    output logic        rw,
    output logic [7:0]  data_out,
    output logic        done
);

    dma_state_t  state_r;
    logic [7:0]  page_r;
    logic [7:0]  index_r;
    logic        trigger_s;

    assign trigger_s = (cpu_rw == 1'b0) && (cpu_addr == TRIGGER_ADDR) && (dma_active == 1'b0);
    assign cpu_halt  = dma_active;

`ifdef OAM_DMA_ALIGN_EN
    logic parity_r;

    // Free-running get/put phase; 0 marks a read-eligible cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ~parity_r;
        end
    end
`endif

    // Transfer sequencer with registered bus outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r    <= ST_IDLE;
            page_r     <= 8'h00;
            index_r    <= 8'h00;
            dma_active <= 1'b0;
            addr       <= 16'h0000;
            rw         <= 1'b1;
            data_out   <= 8'h00;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rw <= 1'b1;
                    if (trigger_s) begin
                        page_r     <= cpu_data;
                        index_r    <= 8'h00;
                        dma_active <= 1'b1;
                        addr       <= src_addr(cpu_data, 8'h00);
                        state_r    <= ST_HALT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    // Stall one more dummy read when the next cycle would be a put cycle.
                    if (parity_r == 1'b0) begin
                        state_r <= ST_ALIGN;
                    end else begin
                        addr    <= src_addr(page_r, index_r);
                        state_r <= ST_READ;
                    end
`else
                    addr    <= src_addr(page_r, index_r);
                    state_r <= ST_READ;
`endif
                end
`ifdef OAM_DMA_ALIGN_EN
                ST_ALIGN: begin
                    addr    <= src_addr(page_r, index_r);
                    state_r <= ST_READ;
                end
`endif
                ST_READ: begin
                    data_out <= data_in;
                    addr     <= DEST_ADDR;
                    rw       <= 1'b0;
                    state_r  <= ST_WRITE;
                end
                ST_WRITE: begin
                    rw <= 1'b1;
                    if (index_r == 8'hFF) begin
                        dma_active <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        index_r <= index_r + 8'd1;
                        addr    <= src_addr(page_r, index_r + 8'd1);
                        state_r <= ST_READ;
                    end
                end
                default: begin
                    dma_active <= 1'b0;
                    rw         <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_2a03.sv
// Randomized self-checking bench for oam_dma_2a03 with a cycle-trace reference model.
module tb_oam_dma_2a03;
    import oam_dma_pkg::*;

    logic        clock, nreset;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data, data_in;
    logic        dma_active, cpu_halt, rw, done;
    logic [15:0] addr;
    logic [7:0]  data_out;

    oam_dma_2a03 dut (
        .clock(clock), .nreset(nreset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data(cpu_data), .data_in(data_in), .dma_active(dma_active),
        .cpu_halt(cpu_halt), .addr(addr), .rw(rw), .data_out(data_out), .done(done)
    );

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    typedef struct packed {
        logic        act;
        logic        chk_a;
        logic [15:0] a;
        logic        r;
        logic        chk_d;
        logic [7:0]  d;
        logic        dn;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mem [0:65535];
    int          n_cmp = 0, n_fail = 0, cnt = 0;
    int          act_len = 0, wr_cnt = 0;
    logic [7:0]  first_wd, last_wd;
    logic [15:0] last_rd, rd_min;
    logic        saw0, done_seen;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected bus trace of one whole transfer, one entry per cycle after the trigger edge.
    task automatic build(input logic [7:0] pg, input int n);
        bit al;
        al = ALIGN_ON && ((n % 2) == 0);
        q.push_back('{act:1'b1, chk_a:1'b1, a:{pg, 8'h00}, r:1'b1, chk_d:1'b0, d:8'h00, dn:1'b0});
        if (al) q.push_back('{act:1'b1, chk_a:1'b1, a:{pg, 8'h00}, r:1'b1, chk_d:1'b0, d:8'h00, dn:1'b0});
        for (int i = 0; i < 256; i++) begin
            q.push_back('{act:1'b1, chk_a:1'b1, a:{pg, 8'(i)}, r:1'b1, chk_d:1'b0, d:8'h00, dn:1'b0});
            q.push_back('{act:1'b1, chk_a:1'b1, a:16'h2004, r:1'b0, chk_d:1'b1, d:mem[{pg, 8'(i)}], dn:1'b0});
        end
        q.push_back('{act:1'b0, chk_a:1'b0, a:16'h0000, r:1'b1, chk_d:1'b0, d:8'h00, dn:1'b1});
    endtask

    // Model update at posedge, per-cycle compare and memory response at negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            if (!nreset) begin
                cnt = 0;
                q.delete();
            end else begin
                cnt = cnt + 1;
                if (q.size() == 0 && cpu_rw == 1'b0 && cpu_addr == 16'h4014) build(cpu_data, cnt);
            end
            @(negedge clock);
            if (!nreset) begin
                q.delete();
                e = '{act:1'b0, chk_a:1'b1, a:16'h0000, r:1'b1, chk_d:1'b1, d:8'h00, dn:1'b0};
            end else if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e = '{act:1'b0, chk_a:1'b0, a:16'h0000, r:1'b1, chk_d:1'b0, d:8'h00, dn:1'b0};
            end
            n_cmp++;
            if (dma_active !== e.act || cpu_halt !== e.act || rw !== e.r || done !== e.dn ||
                (e.chk_a && addr !== e.a) || (e.chk_d && data_out !== e.d)) begin
                n_fail++;
                $display("FAIL bus_cycle t=%0t: got act=%b halt=%b addr=%h rw=%b data=%h done=%b; want act=%b addr=%h(chk %b) rw=%b data=%h(chk %b) done=%b",
                         $time, dma_active, cpu_halt, addr, rw, data_out, done,
                         e.act, e.a, e.chk_a, e.r, e.d, e.chk_d, e.dn);
            end
            if (dma_active) begin
                act_len++;
                if (addr == 16'h0000) saw0 = 1'b1;
                if (rw) begin
                    last_rd = addr;
                    if (addr < rd_min) rd_min = addr;
                end else begin
                    if (wr_cnt == 0) first_wd = data_out;
                    last_wd = data_out;
                    wr_cnt++;
                end
            end
            if (done) done_seen = 1'b1;
            data_in = mem[dma_active ? addr : cpu_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    task automatic noise(input int n, input bit allow_trig);
        for (int i = 0; i < n; i++) begin
            @(negedge clock); #1;
            cpu_rw   = 1'($urandom);
            cpu_addr = 16'($urandom);
            cpu_data = 8'($urandom);
            if (!allow_trig && cpu_addr == 16'h4014) cpu_addr = 16'h4015;
            if (allow_trig && (i % 4) == 0) begin
                cpu_addr = 16'h4014;
                cpu_rw   = 1'b0;
            end
        end
        @(negedge clock); #1;
        cpu_rw = 1'b1;
    endtask

    task automatic cpu_acc(input logic [15:0] a, input logic r, input logic [7:0] d);
        @(negedge clock); #1;
        cpu_addr = a; cpu_rw = r; cpu_data = d;
        @(negedge clock); #1;
        cpu_rw = 1'b1; cpu_addr = 16'h8000;
    endtask

    // par: 1 = trigger edge number odd, 0 = even, -1 = don't care.
    task automatic xfer(input logic [7:0] pg, input int par);
        act_len = 0; wr_cnt = 0; last_rd = 16'h0000; rd_min = 16'hFFFF;
        saw0 = 1'b0; done_seen = 1'b0;
        @(negedge clock); #1;
        if (par >= 0 && ((cnt + 1) % 2) != par) begin
            @(negedge clock); #1;
        end
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data = pg;
        @(negedge clock); #1;
        cpu_rw = 1'b1; cpu_addr = 16'h8000 | 16'($urandom_range(0, 32767)); cpu_data = 8'($urandom);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done_seen && k < bound) begin
            @(negedge clock); #1;
            k++;
        end
        n_cmp++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, want one pulse", bound);
        end
    endtask

    initial begin
        int k;
        nreset = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_data = 8'h00; data_in = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        noise(12, 1'b1);
        chk("reset_active", {31'd0, dma_active}, 32'd0);
        chk("reset_rw", {31'd0, rw}, 32'd1);
        @(negedge clock); #1 nreset = 1'b1;
        noise(5, 1'b0);

        xfer(8'h02, 1);
        wait_done(600);
        chk("p02_len", act_len, 32'd513);
        chk("p02_writes", wr_cnt, 32'd256);
        chk("p02_first_data", {24'd0, first_wd}, 32'h0000_00A5);
        chk("p02_last_data", {24'd0, last_wd}, 32'h0000_005A);
        chk("p02_min_read", {16'd0, rd_min}, 32'h0000_0200);
        chk("p02_last_read", {16'd0, last_rd}, 32'h0000_02FF);

        xfer(8'($urandom), 0);
        wait_done(600);
        chk("even_edge_len", act_len, ALIGN_ON ? 32'd514 : 32'd513);
        xfer(8'($urandom), 1);
        wait_done(600);
        chk("odd_edge_len", act_len, 32'd513);

        xfer(8'hFF, -1);
        wait_done(600);
        chk("pff_last_read", {16'd0, last_rd}, 32'h0000_FFFF);
        chk("pff_no_0000", {31'd0, saw0}, 32'd0);
        chk("pff_writes", wr_cnt, 32'd256);

        xfer(8'($urandom), -1);
        k = 0;
        while (wr_cnt != 101 && k < 600) begin
            @(negedge clock); #1;
            k++;
        end
        chk("rst_reached_byte100", wr_cnt, 32'd101);
        nreset = 1'b0;
        #1;
        chk("rst_async_active", {31'd0, dma_active}, 32'd0);
        chk("rst_async_rw", {31'd0, rw}, 32'd1);
        chk("rst_async_addr", {16'd0, addr}, 32'd0);
        repeat (3) @(negedge clock);
        #1 nreset = 1'b1;
        done_seen = 1'b0;
        noise(20, 1'b0);
        chk("rst_no_more_writes", wr_cnt, 32'd101);
        chk("rst_no_done", {31'd0, done_seen}, 32'd0);
        xfer(8'h03, -1);
        wait_done(600);
        chk("p03_min_read", {16'd0, rd_min}, 32'h0000_0300);
        chk("p03_last_read", {16'd0, last_rd}, 32'h0000_03FF);
        chk("p03_writes", wr_cnt, 32'd256);

        act_len = 0;
        cpu_acc(16'h4013, 1'b0, 8'h05);
        cpu_acc(16'h4015, 1'b0, 8'h06);
        cpu_acc(16'h4014, 1'b1, 8'h07);
        noise(6, 1'b0);
        chk("ignored_no_active", act_len, 32'd0);

        for (int t = 0; t < 4; t++) begin
            noise($urandom_range(3, 20), 1'b0);
            xfer(8'($urandom), -1);
            wait_done(600);
            chk("rand_writes", wr_cnt, 32'd256);
        end
        noise(4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
